// File: rtl/sens_seq_pkg.sv
// Shared definitions for the sensor ADC sequencer.
// The averaging feature (ST_ACCUM state) exists only when SENS_AVG_EN is defined.
package sens_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CONVERT = 3'd3,
        ST_EMIT    = 3'd4,
        ST_DONE    = 3'd5
`ifdef SENS_AVG_EN
        , ST_ACCUM = 3'd6
`endif
    } seq_state_t;

    localparam logic [1:0] SENS_0       = 2'd0;
    localparam logic [1:0] SENS_1       = 2'd1;
    localparam logic [1:0] SENS_2       = 2'd2;
    localparam logic [7:0] TIMEOUT_CODE = 8'hFF;

    // Lowest set bit of the remaining sensor mask (empty mask is handled by the caller).
    function automatic logic [1:0] lowest_idx(input logic [2:0] mask);
        if (mask[0])      return SENS_0;
        else if (mask[1]) return SENS_1;
        else if (mask[2]) return SENS_2;
        else              return SENS_0;
    endfunction

endpackage

// File: rtl/sens_avg_accum.sv
// Unsigned sample accumulator; result is the truncated mean of 2**LOG2 samples.
// Only instantiated when SENS_AVG_EN is defined.
module sens_avg_accum
    import sens_seq_pkg::*;
#(
    parameter int IN_W = 8,
    parameter int LOG2 = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_clr,
    input  logic            i_add,
    input  logic [IN_W-1:0] i_din,
    output logic [IN_W-1:0] o_result
);

    logic [IN_W+LOG2-1:0] r_sum;

    // Sum grows by LOG2 bits so 2**LOG2 full-scale samples never overflow.
    always_ff @(posedge clk) begin
        if (reset || i_clr)
            r_sum <= '0;
        else if (i_add)
            r_sum <= r_sum + (IN_W+LOG2)'(i_din);
    end

    assign o_result = IN_W'(r_sum >> LOG2);

endmodule

// File: rtl/sensor_adc_sequencer.sv
// Sensor ADC sequencer: walks enabled sensors in ascending order, settles the mux,
// runs the ADC start/EOC handshake with a timeout and emits one result per sensor.
// Optional build macro SENS_AVG_EN: average 2**AVG_LOG2 conversions per sensor.
module sensor_adc_sequencer
    import sens_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int CONV_TIMEOUT  = 255,
    parameter int AVG_LOG2      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sens_req,
    input  logic [2:0] senscode,
    output logic [1:0] adc_mux_sel,
    output logic       adc_start,
    input  logic       adc_eoc,
    input  logic [7:0] adc_dout,
    output logic [7:0] ADC_data,
    output logic       ADC_data_ready,
    output logic [1:0] sens_idx,
    output logic       seq_busy,
    output logic       seq_done,
    output logic       timeout_err
);

    localparam int CNT_MAX = (SETTLE_CYCLES > CONV_TIMEOUT) ? SETTLE_CYCLES : CONV_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    // AVG_LOG2 also sizes the accumulator, so keep it sane in every build.
    if (AVG_LOG2 < 1 || AVG_LOG2 > 7) begin : g_avg_range
        $error("AVG_LOG2 must be in 1..7");
    end

    seq_state_t    r_state;
    logic [2:0]    r_mask;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_mux_sel;
    logic          r_start;
    logic [7:0]    r_data;
    logic          r_ready;
    logic [1:0]    r_idx;
    logic          r_busy;
    logic          r_done;
    logic          r_terr;

    logic [1:0]    w_pick;
    logic          w_settle_end;
    logic          w_conv_end;

    assign w_pick       = lowest_idx(r_mask);
    assign w_settle_end = (r_cnt == CW'(SETTLE_CYCLES - 1));
    assign w_conv_end   = (r_cnt == CW'(CONV_TIMEOUT));

`ifdef SENS_AVG_EN
    localparam logic [AVG_LOG2:0] LAST_SMP = (AVG_LOG2+1)'((1 << AVG_LOG2) - 1);

    logic [AVG_LOG2:0] r_smp;
    logic [7:0]        w_avg;
    logic              w_add;
    logic              w_clr;

    assign w_add = (r_state == ST_CONVERT) && adc_eoc;
    assign w_clr = (r_state == ST_SELECT);

    sens_avg_accum #(.IN_W(8), .LOG2(AVG_LOG2)) u_accum (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (w_clr),
        .i_add    (w_add),
        .i_din    (adc_dout),
        .o_result (w_avg)
    );
`endif

    // Sequencer FSM: all outputs are registered; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_mask    <= '0;
            r_cnt     <= '0;
            r_mux_sel <= '0;
            r_start   <= 1'b0;
            r_data    <= '0;
            r_ready   <= 1'b0;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_terr    <= 1'b0;
`ifdef SENS_AVG_EN
            r_smp     <= '0;
`endif
        end else begin
            r_start <= 1'b0;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                // DONE already has busy low, so a request there is accepted like IDLE.
                ST_IDLE, ST_DONE: begin
                    if (sens_req) begin
                        r_mask  <= senscode;
                        r_terr  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SELECT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SELECT: begin
                    if (r_mask == 3'b000) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_mux_sel <= w_pick;
                        r_mask    <= r_mask & ~(3'b001 << w_pick);
                        r_cnt     <= '0;
                        r_state   <= ST_SETTLE;
`ifdef SENS_AVG_EN
                        r_smp     <= '0;
`endif
                    end
                end
                ST_SETTLE: begin
                    if (w_settle_end) begin
                        r_cnt   <= '0;
                        r_start <= 1'b1;
                        r_state <= ST_CONVERT;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                // eoc wins over a coincident timeout expiry.
                ST_CONVERT: begin
                    if (adc_eoc) begin
`ifdef SENS_AVG_EN
                        r_state <= ST_ACCUM;
`else
                        r_data  <= adc_dout;
                        r_idx   <= r_mux_sel;
                        r_ready <= 1'b1;
                        r_state <= ST_EMIT;
`endif
                    end else if (w_conv_end) begin
                        r_data  <= TIMEOUT_CODE;
                        r_idx   <= r_mux_sel;
                        r_ready <= 1'b1;
                        r_terr  <= 1'b1;
                        r_state <= ST_EMIT;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
`ifdef SENS_AVG_EN
                // Accumulator has absorbed the sample; restart without re-settling.
                ST_ACCUM: begin
                    if (r_smp == LAST_SMP) begin
                        r_data  <= w_avg;
                        r_idx   <= r_mux_sel;
                        r_ready <= 1'b1;
                        r_state <= ST_EMIT;
                    end else begin
                        r_smp   <= r_smp + 1'b1;
                        r_cnt   <= '0;
                        r_start <= 1'b1;
                        r_state <= ST_CONVERT;
                    end
                end
`endif
                ST_EMIT: r_state <= ST_SELECT;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign adc_mux_sel    = r_mux_sel;
    assign adc_start      = r_start;
    assign ADC_data       = r_data;
    assign ADC_data_ready = r_ready;
    assign sens_idx       = r_idx;
    assign seq_busy       = r_busy;
    assign seq_done       = r_done;
    assign timeout_err    = r_terr;

endmodule

// File: tb/tb_sensor_adc_sequencer.sv
// Scoreboard bench for sensor_adc_sequencer: directed sequences push expected
// results; a negedge monitor pops and compares on every ADC_data_ready.
module tb_sensor_adc_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sens_req = 1'b0;
    logic [2:0] senscode = 3'b000;
    logic       adc_eoc = 1'b0;
    logic [7:0] adc_dout = 8'h00;
    logic [1:0] adc_mux_sel;
    logic       adc_start;
    logic [7:0] ADC_data;
    logic       ADC_data_ready;
    logic [1:0] sens_idx;
    logic       seq_busy;
    logic       seq_done;
    logic       timeout_err;

`ifdef SENS_AVG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    sensor_adc_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .sens_req       (sens_req),
        .senscode       (senscode),
        .adc_mux_sel    (adc_mux_sel),
        .adc_start      (adc_start),
        .adc_eoc        (adc_eoc),
        .adc_dout       (adc_dout),
        .ADC_data       (ADC_data),
        .ADC_data_ready (ADC_data_ready),
        .sens_idx       (sens_idx),
        .seq_busy       (seq_busy),
        .seq_done       (seq_done),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] idx;
        logic [7:0] data;
        bit         tmo;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] adc_vals[$];
    int eoc_dly    = 10;
    int last_start = -1000;
    int last_eoc   = -1000;
    int n_start    = 0;
    int checks     = 0;
    int failures   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: counts starts and checks every result against the scoreboard.
    always @(negedge clk) begin
        if (adc_start) begin
            n_start++;
            last_start = cyc;
        end
        if (ADC_data_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready: idx %0d data %0h with empty scoreboard (cycle %0d)",
                         sens_idx, ADC_data, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ready_idx", 32'(sens_idx), 32'(e.idx));
                chk("ready_data", 32'(ADC_data), 32'(e.data));
                chk("ready_cycle", 32'(cyc), e.tmo ? 32'(last_start + 256) : 32'(last_eoc + LAT));
            end
        end
    end

    // ADC model: eoc eoc_dly cycles after each start (never if eoc_dly <= 0).
    initial begin
        forever begin
            @(negedge clk);
            if (adc_start && eoc_dly > 0) begin
                repeat (eoc_dly) @(posedge clk);
                #1;
                adc_eoc  = 1'b1;
                adc_dout = (adc_vals.size() > 0) ? adc_vals.pop_front() : 8'h00;
                last_eoc = cyc;
                @(posedge clk);
                #1;
                adc_eoc  = 1'b0;
            end
        end
    end

    task automatic send(input logic [2:0] code, output int n);
        @(posedge clk);
        #1;
        sens_req = 1'b1;
        senscode = code;
        n = cyc;
        @(posedge clk);
        #1;
        sens_req = 1'b0;
        senscode = 3'b000;
    endtask

    task automatic wait_done(input int budget, output int dc);
        dc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (seq_done) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) begin
            checks++;
            failures++;
            $display("FAIL done_wait: no seq_done within %0d cycles", budget);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, dc, s0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'({adc_mux_sel, adc_start, ADC_data, ADC_data_ready,
                                 sens_idx, seq_busy, seq_done, timeout_err}), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

`ifdef SENS_AVG_EN
        // Averaging: 10,11,12,14 -> 47>>2 = 11, one result, four starts.
        s0 = n_start;
        eoc_dly = 10;
        adc_vals.push_back(8'd10); adc_vals.push_back(8'd11);
        adc_vals.push_back(8'd12); adc_vals.push_back(8'd14);
        sb.push_back('{idx: 2'd0, data: 8'd11, tmo: 1'b0});
        send(3'b001, n);
        wait_done(800, dc);
        chk("avg_starts", 32'(n_start - s0), 32'd4);
        chk("avg_sb_empty", 32'(sb.size()), 32'd0);
        chk("avg_busy_low", 32'(seq_busy), 32'd0);
`else
        // Test 1: mask 101, two results in ascending order.
        s0 = n_start;
        eoc_dly = 10;
        adc_vals.push_back(8'h3C); adc_vals.push_back(8'hA5);
        sb.push_back('{idx: 2'd0, data: 8'h3C, tmo: 1'b0});
        sb.push_back('{idx: 2'd2, data: 8'hA5, tmo: 1'b0});
        send(3'b101, n);
        @(negedge clk);
        chk("t1_busy_n1", 32'(seq_busy), 32'd1);
        wait_done(600, dc);
        chk("t1_done_cycle", 32'(dc), 32'(n + 60));
        chk("t1_busy_at_done", 32'(seq_busy), 32'd0);
        chk("t1_starts", 32'(n_start - s0), 32'd2);
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);

        // Test 2: empty mask.
        s0 = n_start;
        send(3'b000, n);
        wait_done(50, dc);
        chk("t2_done_cycle", 32'(dc), 32'(n + 2));
        chk("t2_starts", 32'(n_start - s0), 32'd0);

        // Test 3: sensor 1 never answers -> FF after the timeout.
        s0 = n_start;
        eoc_dly = 0;
        sb.push_back('{idx: 2'd1, data: 8'hFF, tmo: 1'b1});
        send(3'b010, n);
        wait_done(600, dc);
        chk("t3_done_cycle", 32'(dc), 32'(n + 18 + 256 + 2));
        chk("t3_starts", 32'(n_start - s0), 32'd1);
        chk("t3_terr_at_done", 32'(timeout_err), 32'd1);
        repeat (5) @(negedge clk);
        chk("t3_terr_sticky", 32'(timeout_err), 32'd1);

        // Test 4: request during sequence with 111 is dropped.
        s0 = n_start;
        eoc_dly = 10;
        adc_vals.push_back(8'h77);
        sb.push_back('{idx: 2'd0, data: 8'h77, tmo: 1'b0});
        send(3'b001, n);
        @(negedge clk);
        chk("t4_terr_cleared", 32'(timeout_err), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        sens_req = 1'b1;
        senscode = 3'b111;
        @(posedge clk);
        #1;
        sens_req = 1'b0;
        senscode = 3'b000;
        wait_done(600, dc);
        chk("t4_done_cycle", 32'(dc), 32'(n + 31));
        chk("t4_starts", 32'(n_start - s0), 32'd1);
        chk("t4_sb_empty", 32'(sb.size()), 32'd0);

        // Test 5: reset mid-conversion; late eoc must do nothing.
        s0 = n_start;
        eoc_dly = 30;
        adc_vals.push_back(8'h55);
        send(3'b100, n);
        for (int i = 0; i < 100 && n_start == s0; i++) @(negedge clk);
        chk("t5_started", 32'(n_start - s0), 32'd1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("t5_outputs_after_reset", 32'({adc_mux_sel, adc_start, ADC_data, ADC_data_ready,
                                          sens_idx, seq_busy, seq_done, timeout_err}), 32'd0);
        repeat (40) @(negedge clk);
        chk("t5_idle_busy", 32'(seq_busy), 32'd0);
        chk("t5_idle_data", 32'(ADC_data), 32'd0);
        chk("t5_no_restart", 32'(n_start - s0), 32'd1);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
